// File: rtl/axi_ram_slave_if.sv
// rtl/axi_ram_slave_if.sv - AXI4 bus bundle between a master and the RAM responder
interface axi_ram_slave_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 8
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [LEN_W-1:0]    arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI4 responder backed by a word-addressed RAM with calibration delay
module axi_ram_slave #(
    parameter int ID_W         = 4,
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int LEN_W        = 8,
    parameter int MEM_DEPTH    = 1024,
    parameter int CALIB_CYCLES = 64
) (
    input  logic aclk,
    input  logic areset,
    output logic init_calib_complete,
    axi_ram_slave_if.slave s_axi
);
    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CW    = $clog2(CALIB_CYCLES + 1);
    localparam logic [CW-1:0] CALIB_VAL = CW'(CALIB_CYCLES);
    localparam logic [2:0]    FULL_SIZE = 3'(OFF);
    localparam logic [1:0]    SLVERR    = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [CW-1:0] calib_cnt_q, calib_cnt_d;
    logic          calib_done;

    w_state_e         w_state_q, w_state_d;
    logic [ID_W-1:0]  w_id_q;
    logic [IDX_W-1:0] w_idx_q;
    logic [LEN_W-1:0] w_len_q, w_beat_q;
    logic             w_fixed_q, w_err_q, w_size_err_q;
    logic             aw_hs, w_hs, w_last_beat;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q;
    logic [IDX_W-1:0]  r_idx_q, r_next_idx, ar_idx;
    logic [LEN_W-1:0]  r_len_q, r_beat_q;
    logic              r_fixed_q, r_err_q, r_last_q;
    logic [DATA_W-1:0] r_data_q;
    logic              ar_hs, r_hs;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

    // Saturating counter: completion is simply "count has reached the target".
    assign calib_done          = (calib_cnt_q == CALIB_VAL);
    assign calib_cnt_d         = calib_done ? calib_cnt_q : calib_cnt_q + 1'b1;
    assign init_calib_complete = calib_done;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) calib_cnt_q <= '0;
        else        calib_cnt_q <= calib_cnt_d;
    end

    assign aw_hs       = s_axi.awvalid && s_axi.awready;
    assign w_hs        = s_axi.wvalid && s_axi.wready;
    assign w_last_beat = (w_beat_q == w_len_q);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) w_state_q <= W_IDLE;
        else        w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (s_axi.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi.awready = (w_state_q == W_IDLE) && calib_done;
        s_axi.wready  = (w_state_q == W_DATA);
        s_axi.bvalid  = (w_state_q == W_RESP);
        s_axi.bid     = w_id_q;
        s_axi.bresp   = w_err_q ? SLVERR : 2'b00;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_id_q       <= '0;
            w_idx_q      <= '0;
            w_len_q      <= '0;
            w_beat_q     <= '0;
            w_fixed_q    <= 1'b0;
            w_err_q      <= 1'b0;
            w_size_err_q <= 1'b0;
        end else if (aw_hs) begin
            w_id_q       <= s_axi.awid;
            w_idx_q      <= s_axi.awaddr[OFF +: IDX_W];
            w_len_q      <= s_axi.awlen;
            w_beat_q     <= '0;
            w_fixed_q    <= (s_axi.awburst == 2'b00);
            w_size_err_q <= (s_axi.awsize != FULL_SIZE);
            w_err_q      <= s_axi.awburst[1] || (s_axi.awsize != FULL_SIZE);
        end else if (w_hs) begin
            w_idx_q  <= w_fixed_q ? w_idx_q : w_idx_q + 1'b1;
            w_beat_q <= w_beat_q + 1'b1;
            if (s_axi.wlast != w_last_beat) w_err_q <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_size_err_q) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (s_axi.wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    assign ar_hs      = s_axi.arvalid && s_axi.arready;
    assign r_hs       = s_axi.rvalid && s_axi.rready;
    assign ar_idx     = s_axi.araddr[OFF +: IDX_W];
    assign r_next_idx = r_fixed_q ? r_idx_q : r_idx_q + 1'b1;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state_q <= R_IDLE;
        else        r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_last_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi.arready = (r_state_q == R_IDLE) && calib_done;
        s_axi.rvalid  = (r_state_q == R_DATA);
        s_axi.rid     = r_id_q;
        s_axi.rresp   = r_err_q ? SLVERR : 2'b00;
        s_axi.rdata   = r_data_q;
        s_axi.rlast   = r_last_q;
    end

    // Beat data is fetched on the accepting edge, so a same-cycle write to that word is not seen.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_fixed_q <= 1'b0;
            r_err_q   <= 1'b0;
            r_last_q  <= 1'b0;
            r_data_q  <= '0;
        end else if (ar_hs) begin
            r_id_q    <= s_axi.arid;
            r_idx_q   <= ar_idx;
            r_len_q   <= s_axi.arlen;
            r_beat_q  <= '0;
            r_fixed_q <= (s_axi.arburst == 2'b00);
            r_err_q   <= s_axi.arburst[1] || (s_axi.arsize != FULL_SIZE);
            r_last_q  <= (s_axi.arlen == '0);
            r_data_q  <= mem[ar_idx];
        end else if (r_hs && !r_last_q) begin
            r_idx_q  <= r_next_idx;
            r_beat_q <= r_beat_q + 1'b1;
            r_last_q <= ((r_beat_q + 1'b1) == r_len_q);
            r_data_q <= mem[r_next_idx];
        end
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - randomized bench for axi_ram_slave against an array reference model
module tb_axi_ram_slave;
    localparam int ID_W = 4, ADDR_W = 28, DATA_W = 128, LEN_W = 8;
    localparam int MEM_DEPTH = 1024, CALIB_CYCLES = 64, NB = DATA_W / 8, LIM = 500;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic init_calib_complete;
    always #5 aclk = ~aclk;

    axi_ram_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    axi_ram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                    .MEM_DEPTH(MEM_DEPTH), .CALIB_CYCLES(CALIB_CYCLES)) dut (
        .aclk(aclk), .areset(areset), .init_calib_complete(init_calib_complete), .s_axi(bus));

    logic [DATA_W-1:0] model [MEM_DEPTH];
    bit                model_valid [MEM_DEPTH];
    logic [DATA_W-1:0] wd [256];
    logic [NB-1:0]     ws [256];
    int n_checks = 0, n_pass = 0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int word_of(input logic [ADDR_W-1:0] a);
        return (int'(a) / NB) % MEM_DEPTH;
    endfunction

    function automatic int beat_word(input logic [ADDR_W-1:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'd0) ? word_of(a) : (word_of(a) + i) % MEM_DEPTH;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic release_and_calibrate();
        int cyc = 0;
        bit early = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        while (!init_calib_complete && cyc < 200) begin
            if (bus.awready || bus.arready) early = 1'b1;
            @(negedge aclk);
            cyc++;
        end
        check_val("calib_cycles", cyc, CALIB_CYCLES);
        check_val("ready_before_calib", early, 0);
        check_val("awready_at_calib", bus.awready, 1);
    endtask

    task automatic write_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst, input int last_at,
                               input bit skip_aw);
        int cyc;
        logic [1:0] exp_resp;
        if (!skip_aw) begin
            bus.awid = id; bus.awaddr = addr; bus.awlen = LEN_W'(len);
            bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
            cyc = 0;
            while (!bus.awready && cyc < LIM) begin @(negedge aclk); cyc++; end
            if (cyc >= LIM) check_val("aw_timeout", 0, 1);
            @(negedge aclk);
            bus.awvalid = 1'b0;
        end
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin bus.wvalid = 1'b0; @(negedge aclk); end
            bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at);
            cyc = 0;
            while (!bus.wready && cyc < LIM) begin @(negedge aclk); cyc++; end
            if (cyc >= LIM) check_val("w_timeout", 0, 1);
            @(negedge aclk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge aclk);
        bus.bready = 1'b1;
        cyc = 0;
        while (!bus.bvalid && cyc < LIM) begin @(negedge aclk); cyc++; end
        if (cyc >= LIM) check_val("b_timeout", 0, 1);
        exp_resp = (burst >= 2'd2 || size != 3'd4 || last_at != len) ? 2'b10 : 2'b00;
        check_val("bid", bus.bid, id);
        check_val("bresp", bus.bresp, exp_resp);
        @(negedge aclk);
        bus.bready = 1'b0;
        if (size == 3'd4) begin
            for (int i = 0; i <= len; i++) begin
                int w = beat_word(addr, burst, i);
                for (int b = 0; b < NB; b++) if (ws[i][b]) model[w][b*8 +: 8] = wd[i][b*8 +: 8];
                if (&ws[i]) model_valid[w] = 1'b1;
            end
        end
    endtask

    task automatic read_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst, input int rmode);
        logic [DATA_W-1:0] ed [256];
        bit ev [256];
        logic [1:0] exp_resp;
        int cyc, beat;
        bit rr;
        for (int i = 0; i <= len; i++) begin
            ed[i] = model[beat_word(addr, burst, i)];
            ev[i] = model_valid[beat_word(addr, burst, i)];
        end
        exp_resp = (burst >= 2'd2 || size != 3'd4) ? 2'b10 : 2'b00;
        bus.arid = id; bus.araddr = addr; bus.arlen = LEN_W'(len);
        bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
        cyc = 0;
        while (!bus.arready && cyc < LIM) begin @(negedge aclk); cyc++; end
        if (cyc >= LIM) check_val("ar_timeout", 0, 1);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 4 * LIM) begin
            rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.rready = rr;
            check_val("rvalid", bus.rvalid, 1);
            if (ev[beat]) check_val($sformatf("rdata[%0d]", beat), bus.rdata, ed[beat]);
            check_val($sformatf("rlast[%0d]", beat), bus.rlast, beat == len);
            check_val("rid", bus.rid, id);
            check_val("rresp", bus.rresp, exp_resp);
            if (rr) beat++;
            @(negedge aclk);
            cyc++;
        end
        if (beat <= len) check_val("r_timeout", 0, 1);
        bus.rready = 1'b0;
        check_val("rvalid_after_last", bus.rvalid, 0);
        check_val("arready_after_last", bus.arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        repeat (3) @(negedge aclk);
        check_val("rst_calib", init_calib_complete, 0);
        check_val("rst_awready", bus.awready, 0);
        check_val("rst_arready", bus.arready, 0);
        check_val("rst_bvalid", bus.bvalid, 0);
        check_val("rst_rvalid", bus.rvalid, 0);

        bus.awid = 4'd3; bus.awaddr = 28'h100; bus.awlen = 8'd3; bus.awsize = 3'd4; bus.awburst = 2'd1;
        bus.awvalid = 1'b1;
        release_and_calibrate();
        check_val("wready_before_aw", bus.wready, 0);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin wd[i] = DATA_W'(8'hA0 + i); ws[i] = '1; end
        write_burst(4'd3, 28'h100, 3, 3'd4, 2'd1, 3, 1'b1);
        read_burst(4'd5, 28'h100, 3, 3'd4, 2'd1, 0);

        for (int i = 0; i < 4; i++) begin wd[i] = '1; ws[i] = '1; end
        write_burst(4'd1, 28'h200, 3, 3'd4, 2'd1, 3, 1'b0);
        wd[0] = rand_data(); ws[0] = 16'h000F;
        write_burst(4'd2, 28'h200, 0, 3'd4, 2'd1, 0, 1'b0);
        check_val("strobe_model", model[32], {{(DATA_W-32){1'b1}}, wd[0][31:0]});
        read_burst(4'd2, 28'h200, 3, 3'd4, 2'd1, 1);

        for (int i = 0; i < 4; i++) begin wd[i] = rand_data(); ws[i] = '1; end
        write_burst(4'd4, ADDR_W'((MEM_DEPTH - 2) * NB), 3, 3'd4, 2'd1, 3, 1'b0);
        read_burst(4'd4, ADDR_W'((MEM_DEPTH - 2) * NB), 3, 3'd4, 2'd1, 2);
        for (int i = 0; i < 3; i++) begin wd[i] = rand_data(); ws[i] = '1; end
        write_burst(4'd6, ADDR_W'(500 * NB), 2, 3'd4, 2'd0, 2, 1'b0);
        check_val("fixed_model", model[500], wd[2]);
        read_burst(4'd6, ADDR_W'(500 * NB), 0, 3'd4, 2'd1, 0);

        for (int i = 0; i < 4; i++) begin wd[i] = rand_data(); ws[i] = '1; end
        write_burst(4'd7, 28'h100, 3, 3'd2, 2'd1, 3, 1'b0);
        read_burst(4'd7, 28'h100, 3, 3'd4, 2'd1, 0);
        write_burst(4'd8, 28'h300, 3, 3'd4, 2'd1, 1, 1'b0);
        read_burst(4'd9, 28'h100, 3, 3'd4, 2'd2, 2);

        for (int i = 0; i < 8; i++) begin wd[i] = rand_data(); ws[i] = '1; end
        write_burst(4'd1, ADDR_W'(600 * NB), 7, 3'd4, 2'd1, 7, 1'b0);
        for (int i = 0; i < 8; i++) begin wd[i] = rand_data(); ws[i] = 16'($urandom()); end
        fork
            read_burst(4'd10, ADDR_W'(600 * NB), 7, 3'd4, 2'd1, 2);
            write_burst(4'd11, ADDR_W'(700 * NB), 7, 3'd4, 2'd1, 7, 1'b0);
        join
        read_burst(4'd12, ADDR_W'(700 * NB), 7, 3'd4, 2'd1, 0);

        for (int t = 0; t < 12; t++) begin
            logic [ADDR_W-1:0] a = ADDR_W'($urandom());
            int len = $urandom_range(0, 7);
            logic [1:0] bu = 2'($urandom_range(0, 3));
            logic [2:0] sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
            int la = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : len;
            for (int i = 0; i <= len; i++) begin
                wd[i] = rand_data();
                ws[i] = ($urandom_range(0, 1) == 0) ? '1 : 16'($urandom());
            end
            write_burst(4'($urandom()), a, len, sz, bu, la, 1'b0);
            read_burst(4'($urandom()), a ^ ADDR_W'($urandom_range(0, 15)), len, 3'd4, bu, $urandom_range(0, 2));
        end

        bus.arid = 4'd1; bus.araddr = ADDR_W'(600 * NB); bus.arlen = 8'd7; bus.arsize = 3'd4;
        bus.arburst = 2'd1; bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        @(negedge aclk);
        check_val("midread_rvalid", bus.rvalid, 1);
        areset = 1'b1;
        #1;
        check_val("reset_rvalid", bus.rvalid, 0);
        check_val("reset_calib", init_calib_complete, 0);
        repeat (2) @(negedge aclk);
        release_and_calibrate();
        read_burst(4'd2, ADDR_W'(600 * NB), 7, 3'd4, 2'd1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- Synthesizable AXI4 responder: the memory end of the AXI bus that the MIG DDR3 controller normally terminates.
- Used as a drop-in, fast stand-in for the controller. It lets the UVM master driver, monitor and scoreboard run without the DDR3 PHY model.
- Backs the bus with an internal word-addressed RAM.
- Models calibration delay via init_calib_complete.

Parameters:
- ID_W, 4, width of awid/bid/arid/rid
- ADDR_W, 28, byte address width
- DATA_W, 128, data width; power of 2, at least 32
- LEN_W, 8, burst length field width (beats = len+1)
- MEM_DEPTH, 1024, RAM depth in DATA_W words; power of 2
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises

Ports:
- aclk in 1: clock; all logic on rising edge
- areset in 1: asynchronous, active-high reset
- init_calib_complete out 1: calibration-done flag
- awid/awaddr/awlen in ID_W/ADDR_W/LEN_W: write address fields
- awsize in 3: write beat size
- awburst in 2: write burst type
- awvalid in 1 / awready out 1: AW handshake
- wdata/wstrb in DATA_W/DATA_W/8: write data and byte strobes
- wlast in 1: last write beat
- wvalid in 1 / wready out 1: W handshake
- bid/bresp out ID_W/2: write response
- bvalid out 1 / bready in 1: B handshake
- arid/araddr/arlen in ID_W/ADDR_W/LEN_W: read address fields
- arsize in 3: read beat size
- arburst in 2: read burst type
- arvalid in 1 / arready out 1: AR handshake
- rid/rdata/rresp out ID_W/DATA_W/2: read beat fields
- rlast out 1: last read beat
- rvalid out 1 / rready in 1: R handshake

Behaviour:
- Reset: all outputs 0, calib counter 0, both FSMs idle. Reset is asserted asynchronously and released synchronously to aclk. RAM contents are not cleared.
- Reset mid-burst: the burst is abandoned with no response, and calibration restarts.
- Calibration: a counter increments each cycle after reset release. init_calib_complete goes 1 on the cycle the count reaches CALIB_CYCLES and stays 1 until reset. awready and arready are 0 while it is 0.
- Word index = addr[log2(DATA_W/8) +: log2(MEM_DEPTH)]. Upper address bits are ignored, so the address space aliases. Low bits are ignored (aligned access only).
- Burst address: FIXED(0) holds the index; INCR(1) adds 1 per beat, wrapping modulo MEM_DEPTH.
- Burst errors: WRAP(2) and reserved(3) proceed as INCR but respond SLVERR (2'b10).
- Size error: if size != log2(DATA_W/8), the response is SLVERR and RAM writes for that burst are suppressed. Reads in this case return data as normal.
- Otherwise the response is OKAY (2'b00).
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1 when calibrated. On AW handshake, latch id/addr/len/burst/error, set beat count 0, go to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes and advances address and count.
  - The burst ends on the handshake where count==len, regardless of wlast. A wlast mismatch (early, or missing on the final beat) sets SLVERR. Then go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp per flags. Hold until bready, then return to W_IDLE.
- Write ordering: one write burst is outstanding at a time. W beats arriving before AW are not accepted (wready=0).
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1 when calibrated. On AR handshake (cycle T), latch fields and go to R_DATA.
  - R_DATA: rvalid=1 from T+1 with beat 0 data. rid/rresp are constant for the burst. rlast=1 only on beat len.
  - On each rvalid&&rready the next beat is presented on the following cycle with no bubble. rdata/rlast are held stable while rready=0.
  - After the last handshake: rvalid=0, return to R_IDLE. A new AR is accepted at the earliest on the cycle after the last handshake.
- Read and write channels are fully independent and may be active concurrently.
- Same-word collision: a write in the same cycle as a read fetch of that word returns the old data. The new data is visible from the next fetch.

Test Plan:
- Calibration: release reset, hold awvalid=1 -> init_calib_complete=1 exactly 64 cycles after release; awready 0 until then, first AW accepted on that cycle.
- Write then read: AW id=3 addr=0x100 len=3 INCR size=4, 4 beats 0xA0..0xA3 with wstrb all-ones -> bid=3 bresp=0. Then AR id=5 same addr/len -> rid=5, rdata 0xA0..0xA3, rlast only on beat 3, rresp=0.
- Strobe and backpressure: write beat with wstrb=0x000F over 0xFF..FF, then read with rready toggled 1/0 -> only low 4 bytes updated; rdata/rlast stable during stalls.
- Wrap and FIXED: INCR len=3 from word MEM_DEPTH-2 -> words 1022,1023,0,1 written. FIXED len=2 -> only the last beat's data remains in the single word.
- Errors: awsize=2 -> bresp=2'b10 and RAM unchanged. wlast on beat 1 of len=3 -> bresp=2'b10. arburst=2 -> rresp=2'b10 on all beats.
- Concurrency and reset: a read burst in flight during an independent write burst -> both complete correctly. Assert areset mid-read -> rvalid=0 immediately; after recalibration RAM still holds prior data.
